// File: rtl/rhythm_pkg.sv
// Shared constants and types for the rhythm-game lane renderers.
package rhythm_pkg;

  // Sprite geometry and screen coordinate width
  localparam int unsigned SPR_W = 40;
  localparam int unsigned SPR_H = 40;
  localparam int unsigned CW    = 10;

  // Lane left-edge X positions
  localparam int unsigned LANE0_X = 40;
  localparam int unsigned LANE1_X = 80;
  localparam int unsigned LANE2_X = 120;
  localparam int unsigned LANE3_X = 160;

  // Vertical travel and hit window
  localparam int unsigned Y_START   = 100;
  localparam int unsigned Y_MAX     = 400;
  localparam int unsigned HIT_Y_MIN = 340;
  localparam int unsigned HIT_Y_MAX = 399;

  // Keyboard keycodes
  localparam logic [7:0] KEY_START   = 8'h2c;
  localparam logic [7:0] KEY_RESTART = 8'h01;
  localparam logic [7:0] KEY_LANE3   = 8'h07;

  // Hit-flash controller states
  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-derived frame strobe into the pixel clock domain and
// turns each rising edge into a single-cycle tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Two-flop synchroniser, history flop and registered rising-edge pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= frame_clk;
      sync2      <= sync1;
      sync3      <= sync2;
      frame_tick <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/arrow_sprite_renderer.sv
// Per-lane arrow sprite renderer: latches dropper state once per frame,
// tests each VGA pixel against the 40x40 bitmap in a two-stage pipeline,
// and produces a fixed-length hit flash on each new score.
module arrow_sprite_renderer
  import rhythm_pkg::*;
#(
  parameter int unsigned SPR_W        = rhythm_pkg::SPR_W,
  parameter int unsigned SPR_H        = rhythm_pkg::SPR_H,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned CW           = rhythm_pkg::CW
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   pix_valid,
  input  logic [CW-1:0]          DrawX,
  input  logic [CW-1:0]          DrawY,
  input  logic [CW-1:0]          dropX,
  input  logic [CW-1:0]          dropY,
  input  logic [SPR_W*SPR_H-1:0] arrow,
  input  logic                   score,
  output logic                   sprite_on,
  output logic                   flash_on,
  output logic                   pix_valid_out
);

  localparam int unsigned DXW   = $clog2(SPR_W);
  localparam int unsigned DYW   = $clog2(SPR_H);
  localparam int unsigned IDX_W = $clog2(SPR_W * SPR_H);
  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES - 1);

  logic frame_tick;

  frame_tick_sync u_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // ---------------- per-frame shadows ----------------
  logic [CW-1:0]          drop_x_sh;
  logic [CW-1:0]          drop_y_sh;
  logic [SPR_W*SPR_H-1:0] arrow_sh;
  logic                   score_sh;

  // Capture dropper outputs on the frame tick only, so a frame never tears
  always_ff @(posedge Clk) begin
    if (Reset) begin
      drop_x_sh <= '0;
      drop_y_sh <= '0;
      arrow_sh  <= '0;
      score_sh  <= 1'b0;
    end else if (frame_tick) begin
      drop_x_sh <= dropX;
      drop_y_sh <= dropY;
      arrow_sh  <= arrow;
      score_sh  <= score;
    end
  end

  // ---------------- stage 1: box test ----------------
  logic [CW:0]    x_end;
  logic [CW:0]    y_end;
  logic [DXW-1:0] dx_c;
  logic [DYW-1:0] dy_c;
  logic           in_box_c;

  // Box bounds in CW+1 bits so sprites near the screen edge do not wrap
  always_comb begin
    x_end    = {1'b0, drop_x_sh} + (CW+1)'(SPR_W);
    y_end    = {1'b0, drop_y_sh} + (CW+1)'(SPR_H);
    dx_c     = DXW'({1'b0, DrawX} - {1'b0, drop_x_sh});
    dy_c     = DYW'({1'b0, DrawY} - {1'b0, drop_y_sh});
    in_box_c = (DrawX >= drop_x_sh) && ({1'b0, DrawX} < x_end) &&
               (DrawY >= drop_y_sh) && ({1'b0, DrawY} < y_end);
  end

  logic [DXW-1:0] dx1;
  logic [DYW-1:0] dy1;
  logic           in_box1;
  logic           v1;

  // Stage-1 pipeline register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dx1     <= '0;
      dy1     <= '0;
      in_box1 <= 1'b0;
      v1      <= 1'b0;
    end else begin
      dx1     <= dx_c;
      dy1     <= dy_c;
      in_box1 <= in_box_c;
      v1      <= pix_valid;
    end
  end

  // ---------------- stage 2: bitmap lookup ----------------
  logic [IDX_W-1:0] idx;

  // Bitmap index; pinned to 0 outside the box so it never exceeds the bitmap
  always_comb begin
    idx = '0;
    if (in_box1) begin
      idx = IDX_W'(dy1) * IDX_W'(SPR_W) + IDX_W'(dx1);
    end
  end

  // Stage-2 pipeline register driving the colour mapper
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_on     <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      sprite_on     <= v1 & in_box1 & arrow_sh[idx];
      pix_valid_out <= v1;
    end
  end

  // ---------------- hit flash ----------------
  flash_state_t     state;
  flash_state_t     state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             score_rise;

  // The shadow is about to take 'score' while still holding last frame's
  // value, so this is the new-vs-previous shadow comparison one edge early.
  assign score_rise = frame_tick & score & ~score_sh;

  // Flash next-state: start/reload on a score edge, count down per tick
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (score_rise) begin
          state_n = FLASH;
          cnt_n   = CNT_LOAD;
        end
      end
      FLASH: begin
        if (score_rise) begin
          cnt_n = CNT_LOAD;
        end else if (frame_tick) begin
          if (cnt == '0) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Flash state register; flash_on follows the next state so it rises one
  // cycle after the triggering tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      flash_on <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      flash_on <= (state_n == FLASH);
    end
  end

endmodule

// File: doc/arrow_sprite_renderer.md
Name: arrow_sprite_renderer

Overview:
- Consumer end of the dropper interface: takes the lane's `dropX`/`dropY` position, the 40x40 arrow bitmap and the score flag, and turns them into per-pixel hit signals for the colour mapper.
- Shadows the dropper outputs once per frame so the image does not tear.
- Runs a two-stage pixel pipeline against VGA `DrawX`/`DrawY`.
- Drives a short "hit flash" on a new score for the colour mapper.

Parameters:
- SPR_W, 40, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- FLASH_FRAMES, 8, number of frames `flash_on` stays high after a score.
- CW, 10, coordinate width.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame strobe (vsync-derived), asynchronous to Clk.
- pix_valid  in  1  `DrawX`/`DrawY` are an active pixel this cycle.
- DrawX  in  CW  current pixel column.
- DrawY  in  CW  current pixel row.
- dropX  in  CW  sprite left edge, from the dropper.
- dropY  in  CW  sprite top edge, from the dropper.
- arrow  in  SPR_W*SPR_H  bitmap; bit index = row*SPR_W + col.
- score  in  1  dropper score flag.
- sprite_on  out  1  current pipelined pixel hits a set bitmap bit.
- flash_on  out  1  hit-flash active.
- pix_valid_out  out  1  `pix_valid` delayed by 2 cycles.

Behaviour:
- **Clocking and reset.** One clock, Clk; reset is synchronous and active-high, port Reset.
  - Reset clears every register: outputs 0, shadows 0, FSM in IDLE, flash counter 0, synchroniser flops 0.
  - Reset mid-frame or mid-pipeline discards in-flight pixels; `pix_valid_out`=0 on the cycle after Reset.
- **Frame tick.**
  - `frame_clk` passes through a 2-FF synchroniser, then a rising-edge detector.
  - `frame_tick` is a 1-cycle pulse, 3 Clk cycles after the `frame_clk` rise.
  - A held-high `frame_clk` yields exactly one tick.
- **Shadow latch.** On `frame_tick`, capture `dropX`, `dropY`, `arrow` and `score` into shadow registers, and keep the previous `score` shadow. Shadows are otherwise stable.
- **Stage 1** (registered):
  - Compute in CW+1 bits: `dx = DrawX - sX`, `dy = DrawY - sY`.
  - `in_box` = `DrawX >= sX` and `DrawX < sX+SPR_W` and `DrawY >= sY` and `DrawY < sY+SPR_H`.
  - The +SPR_W and +SPR_H sums are done in CW+1 bits, so a sprite near coordinate 1023 does not wrap.
  - Register `dx[5:0]`, `dy[5:0]`, `in_box` and `pix_valid`.
- **Stage 2** (registered):
  - `idx = dy*SPR_W + dx`, 11 bits, always < SPR_W*SPR_H when `in_box`.
  - `sprite_on` = `v1 & in_box1 & arrow_shadow[idx]`.
  - `pix_valid_out` = `v1`.
  - When `in_box1`=0, `idx` is don't-care and must not index out of range; force `idx`=0.
- **Latency.** `sprite_on` for pixel (X,Y) appears exactly 2 Clk cycles after it is presented. Throughput is 1 pixel per clock.
- **Tick during pipeline.** The shadow update takes effect the cycle after `frame_tick`. Each stage uses the shadow value present in its own cycle.
- **Flash FSM.** States IDLE and FLASH.
  - IDLE -> FLASH on `frame_tick` when the new `score` shadow is 1 and the previous one was 0. The counter loads FLASH_FRAMES-1.
  - In FLASH, each `frame_tick` decrements the counter. At a tick with counter=0, go to IDLE.
  - A new 0->1 score edge while in FLASH reloads the counter; stay in FLASH.
  - A `score` that falls during FLASH has no effect.
  - `flash_on` = (state==FLASH), registered. It rises 1 cycle after the triggering tick and stays high for exactly FLASH_FRAMES frame ticks.
  - `score` held at 1 across frames produces a single flash, not a retrigger.

Decomposition:
- Shared package `rhythm_pkg`:
  - constants: SPR_W, SPR_H, CW, lane X positions, Y_start=100, Y_Max=400, hit window 340..399;
  - keycode constants: 8'h2c start, 8'h01 restart, 8'h07 lane 3;
  - `flash_state_t` enum.
- Natural sub-module: `frame_tick_sync` (2-FF synchroniser plus edge detect). It is reusable by every lane renderer.

Test Plan:
1. Reset, then `dropX`=160, `dropY`=100 with a lane-3 bitmap, then one `frame_clk` pulse.
   - Pixel (180,110), which is bit 420 -> `sprite_on`=1 two cycles later.
   - Pixel (160,100), bit 0 -> 0.
   - Pixel (200,110), outside the box -> 0.
2. Scan a full 40x40 box with `pix_valid` high. The captured `sprite_on` map equals the `arrow` shadow bit-for-bit; `pix_valid_out` lags by exactly 2 cycles.
3. Change `dropY` 100->101 mid-frame without a tick -> output unchanged. After the next tick, pixel (180,111) hits bit 420.
4. Edge box with `dropX`=1000: pixel (1023,y) inside -> checked against bitmap; pixel (5,y) -> 0 (no wrap).
5. `score` 0->1 before a tick -> `flash_on` high for exactly 8 ticks, then low. Holding `score`=1 causes no retrigger. Toggling 1->0->1 during the flash reloads to 8.
6. Assert Reset mid-scan and mid-flash -> next cycle `sprite_on`, `flash_on` and `pix_valid_out` are all 0, and the shadows are 0.
